// File: rtl/control_pipe_pkg.sv
// Shared opcode constants, control-bundle layout and ALUOp encodings for the control pipe.
// Pure definitions; no timing or flow control of its own.
package control_pipe_pkg;

    localparam int OPCODE_W     = 7;
    localparam int ALUOP_W      = 2;
    localparam int CTRL_FLAGS_W = 7;

    localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I     = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_S     = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_B     = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR  = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC = 7'b0010111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT  = 2'b10;

    typedef struct packed {
        logic               alusrc;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(input logic [CTRL_FLAGS_W-1:0] flags,
                                      input logic [ALUOP_W-1:0]      aluop);
        return ctrl_t'({flags, aluop});
    endfunction

endpackage

// File: rtl/control_pipe_if.sv
// ID-side inputs and per-stage control outputs of the control pipe.
// Bundle only; no timing or flow control of its own.
interface control_pipe_if #(
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic                      inst_valid;
    logic [INST_WIDTH-1:0]     inst;
    logic                      stall_in;
    logic                      flush;
    logic                      stall_out;
    logic                      ex_valid;
    logic                      ex_alusrc;
    logic                      ex_branch;
    logic                      ex_jump;
    logic [1:0]                ex_aluop;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      mem_valid;
    logic                      mem_read;
    logic                      mem_write;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      wb_valid;
    logic                      wb_regwrite;
    logic                      wb_memtoreg;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      illegal;
    logic [CNT_WIDTH-1:0]      bubble_cnt;

    modport master (
        output inst_valid, inst, stall_in, flush,
        input  stall_out, ex_valid, ex_alusrc, ex_branch, ex_jump, ex_aluop, ex_rd,
               mem_valid, mem_read, mem_write, mem_rd,
               wb_valid, wb_regwrite, wb_memtoreg, wb_rd, illegal, bubble_cnt
    );

    modport slave (
        input  inst_valid, inst, stall_in, flush,
        output stall_out, ex_valid, ex_alusrc, ex_branch, ex_jump, ex_aluop, ex_rd,
               mem_valid, mem_read, mem_write, mem_rd,
               wb_valid, wb_regwrite, wb_memtoreg, wb_rd, illegal, bubble_cnt
    );
endinterface

// File: rtl/control_pipe_decode.sv
// Opcode to control-bundle decoder with source-register usage flags.
// Combinational, zero latency; no flow control.
module control_decode
    import control_pipe_pkg::*;
#(
    parameter bit ENABLE_EXT = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                known,
    output logic                uses_rs1,
    output logic                uses_rs2,
    output logic                has_rd
);
    always_comb begin
        ctrl     = '0;
        known    = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        has_rd   = 1'b1;
        case (opcode)
            OP_R: begin
                ctrl     = mk_ctrl(7'b0010000, ALUOP_FUNCT);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I: begin
                ctrl     = mk_ctrl(7'b1010000, ALUOP_FUNCT);
                uses_rs1 = 1'b1;
            end
            OP_LW: begin
                ctrl     = mk_ctrl(7'b1111000, ALUOP_ADD);
                uses_rs1 = 1'b1;
            end
            // Stores and branches carry immediate bits in the rd field.
            OP_S: begin
                ctrl     = mk_ctrl(7'b1000100, ALUOP_ADD);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                has_rd   = 1'b0;
            end
            OP_B: begin
                ctrl     = mk_ctrl(7'b0000010, ALUOP_BRANCH);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                has_rd   = 1'b0;
            end
            OP_JAL: ctrl = mk_ctrl(7'b0010001, ALUOP_ADD);
            OP_JALR: begin
                if (ENABLE_EXT) begin
                    ctrl     = mk_ctrl(7'b1010001, ALUOP_ADD);
                    uses_rs1 = 1'b1;
                end else begin
                    known = 1'b0;
                end
            end
            OP_LUI, OP_AUIPC: begin
                if (ENABLE_EXT) ctrl = mk_ctrl(7'b1010000, ALUOP_ADD);
                else            known = 1'b0;
            end
            default: known = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_pipe.sv
// ID/EX -> EX/MEM -> MEM/WB control pipe with load-use detection; wb valid 3 cycles after ID.
// stall_in freezes everything; load-use hazard holds ID and injects a bubble; flush kills ID.
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit ENABLE_HAZARD  = 1'b1,
    parameter bit ENABLE_EXT     = 1'b1,
    parameter int CNT_WIDTH      = 16
) (
    input logic           clk,
    input logic           rst_n,
    control_pipe_if.slave bus
);
    logic [REG_ADDR_WIDTH-1:0] id_rd, id_rs1, id_rs2;
    ctrl_t                     dec_ctrl;
    logic                      dec_known, dec_uses_rs1, dec_uses_rs2, dec_has_rd;
    logic                      hazard, stall, bubble;
    logic                      unused_inst_bits;

    logic                      ex_vld_q, ex_vld_d;
    ctrl_t                     ex_ctrl_q, ex_ctrl_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
    logic                      mem_vld_q, mem_vld_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic                      mem_regwrite_q, mem_regwrite_d, mem_memtoreg_q, mem_memtoreg_d;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q, mem_rd_d;
    logic                      wb_vld_q, wb_vld_d, wb_regwrite_q, wb_regwrite_d;
    logic                      wb_memtoreg_q, wb_memtoreg_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                      illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]      bubble_cnt_q, bubble_cnt_d;

    assign id_rd            = bus.inst[7 +: REG_ADDR_WIDTH];
    assign id_rs1           = bus.inst[15 +: REG_ADDR_WIDTH];
    assign id_rs2           = bus.inst[20 +: REG_ADDR_WIDTH];
    assign unused_inst_bits = ^{bus.inst[INST_WIDTH-1:25], bus.inst[14:12]};

    control_decode #(.ENABLE_EXT(ENABLE_EXT)) u_decode (
        .opcode   (bus.inst[OPCODE_W-1:0]),
        .ctrl     (dec_ctrl),
        .known    (dec_known),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .has_rd   (dec_has_rd)
    );

    always_comb begin
        hazard = ENABLE_HAZARD && ex_vld_q && ex_ctrl_q.memread && (ex_rd_q != '0) &&
                 bus.inst_valid &&
                 ((dec_uses_rs1 && (id_rs1 == ex_rd_q)) || (dec_uses_rs2 && (id_rs2 == ex_rd_q)));
        stall  = hazard && !bus.flush;
        bubble = bus.flush || stall || !bus.inst_valid;

        ex_vld_d       = ex_vld_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_rd_d        = ex_rd_q;
        mem_vld_d      = mem_vld_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_regwrite_d = mem_regwrite_q;
        mem_memtoreg_d = mem_memtoreg_q;
        mem_rd_d       = mem_rd_q;
        wb_vld_d       = wb_vld_q;
        wb_regwrite_d  = wb_regwrite_q;
        wb_memtoreg_d  = wb_memtoreg_q;
        wb_rd_d        = wb_rd_q;
        illegal_d      = illegal_q;
        bubble_cnt_d   = bubble_cnt_q;

        if (!bus.stall_in) begin
            // Bubbles load all-zero so every output of an empty stage reads 0.
            ex_vld_d       = !bubble;
            ex_ctrl_d      = bubble ? '0 : dec_ctrl;
            ex_rd_d        = (bubble || !dec_has_rd) ? '0 : id_rd;
            mem_vld_d      = ex_vld_q;
            mem_read_d     = ex_ctrl_q.memread;
            mem_write_d    = ex_ctrl_q.memwrite;
            mem_regwrite_d = ex_ctrl_q.regwrite;
            mem_memtoreg_d = ex_ctrl_q.memtoreg;
            mem_rd_d       = ex_rd_q;
            wb_vld_d       = mem_vld_q;
            wb_regwrite_d  = mem_regwrite_q;
            wb_memtoreg_d  = mem_memtoreg_q;
            wb_rd_d        = mem_rd_q;
            illegal_d      = !bubble && !dec_known;
            if ((bus.flush || stall) && (bubble_cnt_q != {CNT_WIDTH{1'b1}}))
                bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q       <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_rd_q        <= '0;
            mem_vld_q      <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_vld_q       <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_rd_q        <= '0;
            illegal_q      <= 1'b0;
            bubble_cnt_q   <= '0;
        end else begin
            ex_vld_q       <= ex_vld_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_rd_q        <= ex_rd_d;
            mem_vld_q      <= mem_vld_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memtoreg_q <= mem_memtoreg_d;
            mem_rd_q       <= mem_rd_d;
            wb_vld_q       <= wb_vld_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_rd_q        <= wb_rd_d;
            illegal_q      <= illegal_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign bus.stall_out   = stall;
    assign bus.ex_valid    = ex_vld_q;
    assign bus.ex_alusrc   = ex_ctrl_q.alusrc;
    assign bus.ex_branch   = ex_ctrl_q.branch;
    assign bus.ex_jump     = ex_ctrl_q.jump;
    assign bus.ex_aluop    = ex_ctrl_q.aluop;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.mem_valid   = mem_vld_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.wb_valid    = wb_vld_q;
    assign bus.wb_regwrite = wb_regwrite_q;
    assign bus.wb_memtoreg = wb_memtoreg_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.illegal     = illegal_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: decode table, directed pipeline corner cases, randomized run
// against an instruction-level pipeline model. Extra instances cover ENABLE_EXT=0 and CNT_WIDTH=2.
module tb_control_pipe;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] I_LW   = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] I_ADD  = 32'h00728333;  // add x6,x5,x7
    localparam logic [31:0] I_ADDI = 32'h00508193;  // addi x3,x1,5

    control_pipe_if #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) bus();
    control_pipe_if #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) bus_ne();
    control_pipe_if #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  bus_sat();

    control_pipe #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .ENABLE_HAZARD(1'b1),
                   .ENABLE_EXT(1'b1), .CNT_WIDTH(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    control_pipe #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .ENABLE_HAZARD(1'b1),
                   .ENABLE_EXT(1'b0), .CNT_WIDTH(16))
        dut_ne (.clk(clk), .rst_n(rst_n), .bus(bus_ne));
    control_pipe #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .ENABLE_HAZARD(1'b1),
                   .ENABLE_EXT(1'b1), .CNT_WIDTH(2))
        dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_sat));

    assign bus_ne.inst_valid  = bus.inst_valid;
    assign bus_ne.inst        = bus.inst;
    assign bus_ne.stall_in    = bus.stall_in;
    assign bus_ne.flush       = bus.flush;
    assign bus_sat.inst_valid = bus.inst_valid;
    assign bus_sat.inst       = bus.inst;
    assign bus_sat.stall_in   = bus.stall_in;
    assign bus_sat.flush      = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (instruction level) ----------------
    typedef enum {C_R, C_I, C_LW, C_S, C_B, C_JAL, C_JALR, C_UI, C_BAD} cls_e;
    // c = {alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, aluop[1:0]}
    typedef struct packed { logic v; logic [8:0] c; logic [4:0] rd; } slot_t;

    slot_t m_pipe [3];   // [0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB
    int    m_cnt;
    logic  m_ill;

    function automatic cls_e classify(logic [6:0] op, bit ext);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LW;
            7'b0100011: return C_S;
            7'b1100011: return C_B;
            7'b1101111: return C_JAL;
            7'b1100111: return ext ? C_JALR : C_BAD;
            7'b0110111, 7'b0010111: return ext ? C_UI : C_BAD;
            default: return C_BAD;
        endcase
    endfunction

    function automatic logic [8:0] ctl_of(cls_e c);
        case (c)
            C_R:    return 9'b0010000_10;
            C_I:    return 9'b1010000_10;
            C_LW:   return 9'b1111000_00;
            C_S:    return 9'b1000100_00;
            C_B:    return 9'b0000010_01;
            C_JAL:  return 9'b0010001_00;
            C_JALR: return 9'b1010001_00;
            C_UI:   return 9'b1010000_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic bit model_hazard(logic v, logic [31:0] inst, logic f);
        cls_e c  = classify(inst[6:0], 1'b1);
        bit   u1 = (c inside {C_R, C_I, C_LW, C_S, C_B, C_JALR});
        bit   u2 = (c inside {C_R, C_S, C_B});
        logic [4:0] erd = m_pipe[0].rd;
        if (f || !v || !m_pipe[0].v || !m_pipe[0].c[5] || erd == 5'd0) return 1'b0;
        return (u1 && inst[19:15] == erd) || (u2 && inst[24:20] == erd);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_cnt = 0;
        m_ill = 1'b0;
    endtask

    task automatic model_edge(logic v, logic [31:0] inst, logic f, logic s, bit hz);
        cls_e c   = classify(inst[6:0], 1'b1);
        bit   bub = f || hz || !v;
        if (s) return;
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        if (bub) m_pipe[0] = '0;
        else     m_pipe[0] = '{1'b1, ctl_of(c), (c == C_S || c == C_B) ? 5'd0 : inst[11:7]};
        m_ill = !bub && (c == C_BAD);
        if (f || hz) m_cnt++;
    endtask

    function automatic logic [28:0] exp_obs(bit hz);
        return {hz, m_pipe[0].v, m_pipe[0].c[8], m_pipe[0].c[3], m_pipe[0].c[2],
                m_pipe[0].c[1:0], m_pipe[0].rd,
                m_pipe[1].v, m_pipe[1].c[5], m_pipe[1].c[4], m_pipe[1].rd,
                m_pipe[2].v, m_pipe[2].c[6], m_pipe[2].c[7], m_pipe[2].rd, m_ill};
    endfunction

    function automatic logic [28:0] obs();
        return {bus.stall_out, bus.ex_valid, bus.ex_alusrc, bus.ex_branch, bus.ex_jump,
                bus.ex_aluop, bus.ex_rd, bus.mem_valid, bus.mem_read, bus.mem_write, bus.mem_rd,
                bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd, bus.illegal};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [31:0] inst, logic f, logic s);
        bus.inst_valid = v;
        bus.inst       = inst;
        bus.flush      = f;
        bus.stall_in   = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] op;
        case ($urandom_range(0, 10))
            0: op = 7'b0110011;  1: op = 7'b0010011;  2, 3: op = 7'b0000011;
            4: op = 7'b0100011;  5: op = 7'b1100011;  6: op = 7'b1101111;
            7: op = 7'b1100111;  8: op = 7'b0110111;  9: op = 7'b0010111;
            default: op = 7'h7F;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    // ---------------- decode table ----------------
    // ex = {ex_valid, alusrc, branch, jump, aluop[1:0], rd[4:0]}
    typedef struct { logic [31:0] inst; logic [10:0] ex; logic ill; logic ill_ne; } vec_t;
    vec_t vecs [10];

    initial begin
        logic [31:0] cur_inst;
        logic        cur_v, cur_f, cur_s, prev_s;
        bit          hz, prev_hz;

        vecs[0] = '{I_ADD,        11'b1_0_0_0_10_00110, 1'b0, 1'b0};
        vecs[1] = '{I_ADDI,       11'b1_1_0_0_10_00011, 1'b0, 1'b0};
        vecs[2] = '{I_LW,         11'b1_1_0_0_00_00101, 1'b0, 1'b0};
        vecs[3] = '{32'h0050A423, 11'b1_1_0_0_00_00000, 1'b0, 1'b0};  // sw x5,8(x1)
        vecs[4] = '{32'h00208463, 11'b1_0_1_0_01_00000, 1'b0, 1'b0};  // beq x1,x2
        vecs[5] = '{32'h008000EF, 11'b1_0_0_1_00_00001, 1'b0, 1'b0};  // jal x1
        vecs[6] = '{32'h000100E7, 11'b1_1_0_1_00_00001, 1'b0, 1'b1};  // jalr x1,0(x2)
        vecs[7] = '{32'h123453B7, 11'b1_1_0_0_00_00111, 1'b0, 1'b1};  // lui x7
        vecs[8] = '{32'h00001217, 11'b1_1_0_0_00_00100, 1'b0, 1'b1};  // auipc x4
        vecs[9] = '{32'h0000007F, 11'b1_0_0_0_00_00000, 1'b1, 1'b1};  // unknown opcode

        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        chk("reset_obs", 32'(obs()), 32'h0);
        chk("reset_cnt", 32'(bus.bubble_cnt), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].inst, 1'b0, 1'b0);
            step();
            chk($sformatf("dec%0d_ex", i),
                32'({bus.ex_valid, bus.ex_alusrc, bus.ex_branch, bus.ex_jump, bus.ex_aluop, bus.ex_rd}),
                32'(vecs[i].ex));
            chk($sformatf("dec%0d_ill", i), 32'(bus.illegal), 32'(vecs[i].ill));
            chk($sformatf("dec%0d_ill_noext", i), 32'(bus_ne.illegal), 32'(vecs[i].ill_ne));
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            step();
        end
        chk("ill_clears", 32'(bus.illegal), 32'h0);

        // Load-use: one bubble, ADD arrives at wb one cycle late.
        do_reset();
        drive(1'b1, I_LW, 1'b0, 1'b0);
        step();
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        #1 chk("lu_stall", 32'(bus.stall_out), 32'h1);
        step();
        chk("lu_ex_bubble", 32'(bus.ex_valid), 32'h0);
        chk("lu_cnt", 32'(bus.bubble_cnt), 32'h1);
        chk("lu_mem_lw", 32'({bus.mem_valid, bus.mem_read, bus.mem_rd}), 32'b1_1_00101);
        #1 chk("lu_stall_once", 32'(bus.stall_out), 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("lu_ex_add", 32'({bus.ex_valid, bus.ex_rd}), 32'b1_00110);
        step();
        chk("lu_wb_gap", 32'(bus.wb_valid), 32'h0);
        step();
        chk("lu_wb_add", 32'({bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd}),
            32'b1_1_0_00110);
        chk("lu_cnt_final", 32'(bus.bubble_cnt), 32'h1);

        // Flush beats a simultaneous load-use hazard.
        do_reset();
        drive(1'b1, I_LW, 1'b0, 1'b0);
        step();
        drive(1'b1, I_ADD, 1'b1, 1'b0);
        #1 chk("fl_stall_masked", 32'(bus.stall_out), 32'h0);
        step();
        chk("fl_ex_bubble", 32'(bus.ex_valid), 32'h0);
        chk("fl_cnt", 32'(bus.bubble_cnt), 32'h1);
        chk("fl_mem_lw", 32'({bus.mem_valid, bus.mem_read, bus.mem_rd}), 32'b1_1_00101);

        // Global stall freezes all stages for 3 cycles.
        do_reset();
        drive(1'b1, I_ADDI, 1'b0, 1'b0);
        step();
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        step();
        drive(1'b1, I_LW, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("gs%0d_ex", i), 32'({bus.ex_valid, bus.ex_aluop, bus.ex_rd}), 32'b1_10_00110);
            chk($sformatf("gs%0d_mem", i), 32'({bus.mem_valid, bus.mem_rd}), 32'b1_00011);
            chk($sformatf("gs%0d_wb", i), 32'(bus.wb_valid), 32'h0);
        end
        chk("gs_cnt", 32'(bus.bubble_cnt), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("gs_resume_mem", 32'({bus.mem_valid, bus.mem_rd}), 32'b1_00110);
        chk("gs_resume_wb", 32'({bus.wb_valid, bus.wb_rd}), 32'b1_00011);
        step();
        chk("gs_resume_wb_add", 32'({bus.wb_valid, bus.wb_regwrite, bus.wb_rd}), 32'b1_1_00110);

        // Saturation on the 2-bit counter instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, I_ADD, 1'b1, 1'b0);
            step();
            chk($sformatf("sat%0d", i), 32'(bus_sat.bubble_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end
        chk("sat_wide_cnt", 32'(bus.bubble_cnt), 32'd5);

        // Asynchronous reset in the middle of a hazard stall.
        drive(1'b1, I_LW, 1'b0, 1'b0);
        step();
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        #1 chk("mr_pre_stall", 32'(bus.stall_out), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_obs", 32'(obs()), 32'h0);
        chk("mr_cnt", 32'(bus.bubble_cnt), 32'h0);
        chk("mr_sat_cnt", 32'(bus_sat.bubble_cnt), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        // Randomized run against the model.
        do_reset();
        model_reset();
        prev_s   = 1'b0;
        prev_hz  = 1'b0;
        cur_inst = 32'h0;
        cur_v    = 1'b0;
        cur_f    = 1'b0;
        cur_s    = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (prev_s) begin
                // Source holds its request (including flush) across a global stall.
                cur_s = ($urandom_range(0, 2) == 0);
            end else begin
                if (!prev_hz) begin
                    cur_inst = rand_inst();
                    cur_v    = ($urandom_range(0, 7) != 0);
                end
                cur_f = ($urandom_range(0, 9) == 0);
                cur_s = ($urandom_range(0, 9) == 0);
            end
            drive(cur_v, cur_inst, cur_f, cur_s);
            #1;
            hz = model_hazard(cur_v, cur_inst, cur_f);
            chk("rand_obs", 32'(obs()), 32'(exp_obs(hz)));
            chk("rand_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
            chk("rand_sat_cnt", 32'(bus_sat.bubble_cnt), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
            model_edge(cur_v, cur_inst, cur_f, cur_s, hz);
            prev_s  = cur_s;
            prev_hz = hz;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameters: INST_WIDTH, default 32, instruction width; REG_ADDR_WIDTH, default 5, register index width; ENABLE_HAZARD, default 1, load-use detection on/off; ENABLE_EXT, default 1, decode JALR/LUI/AUIPC; CNT_WIDTH, default 16, bubble counter width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports as follows:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inst_valid  input  1  ID instruction present.
- inst  input  INST_WIDTH  ID instruction.
- stall_in  input  1  global freeze, e.g. memory wait.
- flush  input  1  branch/jump taken in EX; kill ID instruction.
- stall_out  output  1  load-use hazard; fetch and ID must hold.
- ex_valid, ex_alusrc, ex_branch, ex_jump  output  1 each  ID/EX stage control.
- ex_aluop  output  2  00 add, 01 branch compare, 10 funct-decoded.
- ex_rd  output  REG_ADDR_WIDTH  ID/EX destination register.
- mem_valid, mem_read, mem_write  output  1 each  EX/MEM stage control.
- mem_rd  output  REG_ADDR_WIDTH  EX/MEM destination register.
- wb_valid, wb_regwrite, wb_memtoreg  output  1 each  MEM/WB stage control.
- wb_rd  output  REG_ADDR_WIDTH  MEM/WB destination register.
- illegal  output  1  registered: last ID instruction had an unknown opcode.
- bubble_cnt  output  CNT_WIDTH  count of bubbles inserted.

Function
REQ-004 SHALL decode opcode inst[6:0] into {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp}:
- R 0110011 -> 0010000,10.
- I-ALU 0010011 -> 1010000,10.
- LW 0000011 -> 1111000,00.
- S 0100011 -> 1000100,00.
- B 1100011 -> 0000010,01.
- JAL 1101111 -> 0010001,00.
- Extended, ENABLE_EXT=1 only: JALR 1100111 -> 1010001,00; LUI 0110111 and AUIPC 0010111 -> 1010000,00.
- Any other opcode -> all zero, and illegal=1 on the next edge.
REQ-005 SHALL take rd from inst[11:7], rs1 from [19:15] and rs2 from [24:20].
REQ-006 SHALL force rd=0 and RegWrite=0 for S and B.
REQ-007 SHALL register the decode into ID/EX one cycle after the ID instruction is presented.
REQ-008 SHALL advance the stages each unstalled edge: ID/EX -> EX/MEM carries mem/wb fields and rd; EX/MEM -> MEM/WB carries wb fields and rd.
REQ-009 SHALL hold wb outputs valid 3 cycles after ID presentation when no stall occurs.
REQ-010 SHALL give every stage a valid bit; all control outputs of a stage SHALL read 0 when that stage's valid=0.
REQ-011 SHALL assert stall_out combinationally when all of the following hold: ENABLE_HAZARD=1, ex_valid, ex_mem_read, ex_rd != 0, inst_valid, and ex_rd matches a used source register.
- rs1 is used by R, I-ALU, LW, S, B, JALR.
- rs2 is used by R, S, B.
REQ-012 SHALL, while stall_out=1, load a bubble (valid=0) into ID/EX, let EX/MEM and MEM/WB advance, increment bubble_cnt, and leave the ID instruction to be re-presented.
REQ-013 SHALL, on flush=1, load a bubble into ID/EX and increment bubble_cnt; flush SHALL override stall_out, forcing stall_out=0 in that cycle.
REQ-014 SHALL, on stall_in=1, freeze every stage register, illegal and bubble_cnt.
- stall_in SHALL take precedence over flush and hazard.
- flush is ignored while stall_in=1, and the source keeps flush asserted until stall_in drops.
REQ-015 SHALL saturate bubble_cnt at all-ones with no wrap-around.
REQ-016 SHALL load a bubble into ID/EX when inst_valid=0, without counting it.

Reset
REQ-017 SHALL, on rst_n=0 at any time including mid-stall, clear all stage registers, valid bits, illegal and bubble_cnt to 0 asynchronously.
REQ-018 SHALL drive stall_out=0 during reset.
REQ-019 SHALL perform its first capture on the first rising clk edge after rst_n deasserts.

Structure
REQ-020 SHALL place the opcode constants, the control-bundle field widths and the ALUOp encodings in the shared constants include.
REQ-021 SHALL use one sub-module, control_decode: a purely combinational opcode-to-bundle decoder that also produces the uses_rs1 and uses_rs2 flags.

Verification
REQ-022 SHALL have the bench cover these directed scenarios:
- Reset: rst_n=0 mid-stream -> all outputs 0 immediately; bubble_cnt=0.
- Load-use: LW x5,0(x1) (0x0000A283) then ADD x6,x5,x7 (0x00728333) -> stall_out=1 for exactly 1 cycle, one bubble, bubble_cnt=1; ADD reaches wb 1 cycle late with wb_rd=6.
- Flush precedence: flush=1 together with a load-use hazard -> stall_out=0, ID/EX bubble, bubble_cnt +1.
- Global stall: stall_in=1 for 3 cycles with ADD in ID/EX -> ex/mem/wb outputs unchanged; ADD resumes afterwards with no loss.
- Illegal and extensions: opcode 0x7F -> illegal=1, ex_valid=1 with zero control; LUI with ENABLE_EXT=0 -> illegal=1.
- Saturation: CNT_WIDTH=2 with 5 flushes -> bubble_cnt=3.
